// File: rtl/fetch_pkg.sv
// Shared widths, constants and FSM encoding for the instruction fetch stage.
package fetch_pkg;
  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP = 64'd4;
  localparam logic [XLEN-1:0] PC_ALIGN_MASK = ~64'h3;

  typedef enum logic {
    FETCH = 1'b0,
    FAULT = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: redirect load (word-aligned), sequential increment, or hold.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc,
  input  logic            load,
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] pc
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= target & PC_ALIGN_MASK;
    end else if (inc) begin
      pc <= pc + PC_STEP;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, IF/ID pipeline register and fault FSM.
// Define FETCH_ALIGN_CHK_EN to trap misaligned redirect targets into the sticky FAULT state.
//
//   state | meaning
//   FETCH | normal fetch; fires when decode can take a new instruction
//   FAULT | misaligned redirect seen; PC frozen, IF/ID empty until reset
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_instr,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [ILEN-1:0] id_instr,
  output logic            fault
);

  fetch_state_e    state_q, state_d;
  logic            fire;
  logic            take_redirect;
  logic            misaligned;
  logic [XLEN-1:0] pc;

`ifdef FETCH_ALIGN_CHK_EN
  assign misaligned = |redirect_pc[1:0];
  assign fault      = (state_q == FAULT);
`else
  assign misaligned = 1'b0;
  assign fault      = 1'b0;
`endif

  fetch_pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (fire),
    .load  (take_redirect),
    .target(redirect_pc),
    .pc    (pc)
  );

  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    fire          = 1'b0;
    take_redirect = 1'b0;
    case (state_q)
      FETCH: begin
        if (redirect_valid) begin
          if (misaligned) begin
            state_d = FAULT;
          end else begin
            take_redirect = 1'b1;
          end
        end else if (!stall && (!id_valid || id_ready)) begin
          fire = 1'b1;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // A redirect flushes IF/ID whether or not decode takes the old contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_valid <= 1'b0;
      id_pc    <= '0;
      id_instr <= NOP_INSTR;
    end else if (state_q == FAULT || redirect_valid) begin
      id_valid <= 1'b0;
    end else if (fire) begin
      id_valid <= 1'b1;
      id_pc    <= pc;
      id_instr <= imem_instr;
    end else if (id_ready) begin
      id_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: reset, streaming, backpressure, redirect, alignment, PC wrap.
module tb_fetch_stage;
  import fetch_pkg::*;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam logic [31:0] W_INSTR = 32'h0010_0093;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [63:0] id_pc;
  logic [31:0] id_instr;
  logic        fault;

  logic        w_rst_n;
  logic        w_stall;
  logic [63:0] w_addr;
  logic        w_id_valid;
  logic [63:0] w_id_pc;
  logic [31:0] w_id_instr;
  logic        w_fault;

  logic [31:0] mem [256];
  exp_t        sb_q[$];
  int          checks = 0;
  int          failures = 0;
  logic        post_stall;

  always #5 clk = ~clk;

  always_comb begin
    if (imem_addr < 64'd1024) imem_instr = mem[imem_addr[9:2]];
    else imem_instr = NOP_INSTR;
  end

  fetch_stage u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_pc         (id_pc),
    .id_instr      (id_instr),
    .fault         (fault)
  );

  fetch_stage #(
    .RESET_PC(WRAP_PC)
  ) u_wrap (
    .clk           (clk),
    .rst_n         (w_rst_n),
    .imem_addr     (w_addr),
    .imem_instr    (W_INSTR),
    .stall         (w_stall),
    .redirect_valid(1'b0),
    .redirect_pc   (64'h0),
    .id_valid      (w_id_valid),
    .id_ready      (1'b1),
    .id_pc         (w_id_pc),
    .id_instr      (w_id_instr),
    .fault         (w_fault)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every IF/ID handshake must match the oldest expected instruction.
  always @(negedge clk) begin
    if (rst_n && id_valid && id_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_underflow", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("sb_pc", id_pc, e.pc);
        check_eq("sb_instr", {32'h0, id_instr}, {32'h0, e.instr});
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = NOP_INSTR;
    mem[0] = 32'h0070_0013;
    mem[1] = 32'h0F20_0A13;
    mem[2] = 32'h0040_0393;

    rst_n = 1'b0;
    w_rst_n = 1'b0;
    w_stall = 1'b1;
    stall = 1'b0;
    id_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 64'h80;
    step();
    step();
    rst_n = 1'b1;
    redirect_valid = 1'b0;
    id_ready = 1'b1;
    check_eq("rst_addr", imem_addr, 64'h0);
    check_eq("rst_valid", {63'h0, id_valid}, 64'h0);
    check_eq("rst_instr", {32'h0, id_instr}, {32'h0, NOP_INSTR});
    check_eq("rst_pc", id_pc, 64'h0);
    check_eq("rst_fault", {63'h0, fault}, 64'h0);

    sb_q.push_back('{pc: 64'h0, instr: 32'h0070_0013});
    sb_q.push_back('{pc: 64'h4, instr: 32'h0F20_0A13});
    sb_q.push_back('{pc: 64'h8, instr: 32'h0040_0393});

    step();
    check_eq("stream0_pc", id_pc, 64'h0);
    check_eq("stream0_valid", {63'h0, id_valid}, 64'h1);
    step();
    check_eq("stream1_pc", id_pc, 64'h4);
    check_eq("stream1_instr", {32'h0, id_instr}, 64'h0F20_0A13);
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("bp_pc", id_pc, 64'h4);
      check_eq("bp_instr", {32'h0, id_instr}, 64'h0F20_0A13);
      check_eq("bp_addr", imem_addr, 64'h8);
      check_eq("bp_valid", {63'h0, id_valid}, 64'h1);
    end
    id_ready = 1'b1;
    step();
    check_eq("resume_pc", id_pc, 64'h8);
    check_eq("resume_instr", {32'h0, id_instr}, 64'h0040_0393);

    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 64'h34;
    step();
    check_eq("redir_valid", {63'h0, id_valid}, 64'h0);
    check_eq("redir_addr", imem_addr, 64'h34);
    stall = 1'b0;
    redirect_valid = 1'b0;
    sb_q.push_back('{pc: 64'h34, instr: NOP_INSTR});
    step();
    check_eq("redir_tgt_valid", {63'h0, id_valid}, 64'h1);
    check_eq("redir_tgt_pc", id_pc, 64'h34);
    check_eq("redir_tgt_instr", {32'h0, id_instr}, {32'h0, NOP_INSTR});
    stall = 1'b1;
    step();
    check_eq("stall_drain_valid", {63'h0, id_valid}, 64'h0);
    check_eq("stall_addr0", imem_addr, 64'h38);
    step();
    check_eq("stall_addr1", imem_addr, 64'h38);

    redirect_valid = 1'b1;
    redirect_pc = 64'h36;
    step();
    redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
    check_eq("align_fault", {63'h0, fault}, 64'h1);
    check_eq("align_addr", imem_addr, 64'h38);
    post_stall = 1'b0;
`else
    check_eq("align_fault", {63'h0, fault}, 64'h0);
    check_eq("align_addr", imem_addr, 64'h34);
    post_stall = 1'b1;
`endif
    check_eq("align_valid", {63'h0, id_valid}, 64'h0);
    stall = post_stall;
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("post_align_valid", {63'h0, id_valid}, 64'h0);
`ifdef FETCH_ALIGN_CHK_EN
      check_eq("post_align_addr", imem_addr, 64'h38);
      check_eq("post_align_fault", {63'h0, fault}, 64'h1);
`else
      check_eq("post_align_addr", imem_addr, 64'h34);
      check_eq("post_align_fault", {63'h0, fault}, 64'h0);
`endif
    end

    rst_n = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 64'h100;
    step();
    check_eq("rst2_addr", imem_addr, 64'h0);
    check_eq("rst2_valid", {63'h0, id_valid}, 64'h0);
    check_eq("rst2_fault", {63'h0, fault}, 64'h0);
    check_eq("rst2_instr", {32'h0, id_instr}, {32'h0, NOP_INSTR});
    stall = 1'b1;
    redirect_valid = 1'b0;
    rst_n = 1'b1;

    w_rst_n = 1'b1;
    step();
    check_eq("wrap_rst_addr", w_addr, WRAP_PC);
    w_stall = 1'b0;
    step();
    w_stall = 1'b1;
    check_eq("wrap_addr", w_addr, 64'h0);
    check_eq("wrap_id_pc", w_id_pc, WRAP_PC);
    check_eq("wrap_valid", {63'h0, w_id_valid}, 64'h1);
    check_eq("wrap_instr", {32'h0, w_id_instr}, {32'h0, W_INSTR});
    check_eq("wrap_fault", {63'h0, w_fault}, 64'h0);
    step();
    check_eq("wrap_hold_addr", w_addr, 64'h0);

    check_eq("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, the PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port imem_addr  output  64  byte address to instr_mem, equal to the current PC register.
REQ-005 SHALL have port imem_instr  input  32  instruction returned combinationally by instr_mem for imem_addr.
REQ-006 SHALL have port stall  input  1  hazard-unit freeze of PC and fetch.
REQ-007 SHALL have port redirect_valid  input  1  taken branch/jump from execute.
REQ-008 SHALL have port redirect_pc  input  64  branch/jump target.
REQ-009 SHALL have port id_valid  output  1  IF/ID register holds a valid instruction.
REQ-010 SHALL have port id_ready  input  1  decode accepts the IF/ID contents this cycle.
REQ-011 SHALL have port id_pc  output  64  PC of the held instruction.
REQ-012 SHALL have port id_instr  output  32  held instruction word.
REQ-013 SHALL have port fault  output  1  misaligned-target fault flag (sticky).

Function
REQ-014 SHALL define fire = state==FETCH && !stall && !redirect_valid && (!id_valid || id_ready).
REQ-015 SHALL on fire load id_pc<=PC, id_instr<=imem_instr, id_valid<=1, PC<=PC+4 (modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC wraps to 0).
REQ-016 SHALL, when id_valid && id_ready && !fire, clear id_valid next cycle.
REQ-017 SHALL hold PC, id_pc, id_instr stable while id_valid && !id_ready, or while stall is high, with no redirect.
REQ-018 SHALL give redirect_valid priority over stall and fire: next cycle PC<=target, id_valid<=0 (flush); no instruction captured that cycle.
REQ-019 SHALL take first instruction at redirect target one cycle after redirect (redirect-to-id_valid latency 2 cycles when unstalled).
REQ-020 SHALL implement states FETCH and FAULT; FETCH->FAULT only per REQ-029; FAULT exits only by reset.
REQ-021 SHALL in FAULT never fire, hold PC, and clear id_valid.
REQ-022 SHALL sustain one instruction per cycle when stall=0, id_ready=1, no redirect.

Reset
REQ-023 SHALL on clk edge with rst_n=0 set PC<=RESET_PC, state<=FETCH, id_valid<=0, id_pc<=0, id_instr<=32'h00000013 (NOP), fault<=0.
REQ-024 SHALL let reset override redirect, stall and handshake in the same cycle; in-flight IF/ID contents discarded.
REQ-025 SHALL drive imem_addr=RESET_PC in the first cycle after reset release.

Configuration
REQ-026 SHALL provide macro FETCH_ALIGN_CHK_EN.
REQ-027 SHALL, without the macro, load PC<={redirect_pc[63:2],2'b00} on redirect and tie fault to 0; state never leaves FETCH.
REQ-028 SHALL, with the macro, treat redirect_pc[1:0]==0 as REQ-018.
REQ-029 SHALL, with the macro and redirect_pc[1:0]!=0, keep PC, set fault<=1, id_valid<=0, state<=FAULT next cycle.

Structure
REQ-030 SHALL place XLEN=64, ILEN=32, NOP_INSTR=32'h00000013, PC_STEP=4 and the FETCH/FAULT state enum in shared package fetch_pkg.
REQ-031 SHALL use one sub-module, fetch_pc_reg (PC register with increment/redirect/hold mux); IF/ID register and FSM stay in fetch_stage.

Verification
REQ-032 SHALL test reset: rst_n=0 two cycles, release -> imem_addr=0, id_valid=0, id_instr=00000013, fault=0.
REQ-033 SHALL test streaming: stall=0, id_ready=1, mem[0..2]=00700013,0F200A13,00400393 -> id_pc 0,4,8 with those words on consecutive cycles.
REQ-034 SHALL test backpressure: id_ready=0 at id_pc=4 for 3 cycles -> id_pc=4, id_instr=0F200A13, imem_addr=8 held; resumes with id_pc=8.
REQ-035 SHALL test redirect over stall: stall=1, redirect_valid=1, redirect_pc=0x34 -> next cycle id_valid=0, imem_addr=0x34; following cycle (stall=0) id_pc=0x34, id_instr=00000013.
REQ-036 SHALL test alignment: redirect_pc=0x36 -> macro on: fault=1, imem_addr unchanged, id_valid stays 0; macro off: imem_addr=0x34, fault=0.
REQ-037 SHALL test wrap: RESET_PC=64'hFFFF_FFFF_FFFF_FFFC, one fire -> imem_addr=0, id_pc=64'hFFFF_FFFF_FFFF_FFFC.
